nested_phase_oscillator: RTL and testbench

Parametrised global phase generator for the Phase-based Spiking Transformer. It produces a fast gamma phase ramp and nests it inside a slower theta rhythm, giving a gamma-slot index and theta-start pulse for phase-coded sequence tokens. Cycle length and gammas-per-theta are runtime-programmable through a valid/ready handshake and take effect glitch-free at a theta boundary. Enable freeze and synchronous phase resync let multiple cores share or re-align a common time base.

---
 rtl/nested_phase_oscillator_if.sv | 31 +++
 rtl/nested_phase_oscillator.sv | 150 +++++++++++++++
 tb/tb_nested_phase_oscillator.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/nested_phase_oscillator_if.sv
`default_nettype none
// ============================================================================
// Module      : nested_phase_oscillator_if
// Description : Configuration valid/ready channel for the nested phase
//               oscillator (cycle length and gammas-per-theta).
// Revision    : 1.0 - initial release
// ============================================================================
interface nested_phase_oscillator_if #(
  parameter int PHASE_W = 8,
  parameter int SLOT_W  = 3
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [PHASE_W:0]   cfg_cycle_len;
  logic [SLOT_W:0]    cfg_gammas;

  modport master (
    output cfg_valid,
    output cfg_cycle_len,
    output cfg_gammas,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_cycle_len,
    input  cfg_gammas,
    output cfg_ready
  );
endinterface
`default_nettype wire

// File: rtl/nested_phase_oscillator.sv
`default_nettype none
// ============================================================================
// Module      : nested_phase_oscillator
// Description : Gamma phase ramp nested inside a theta rhythm. Produces the
//               gamma phase, gamma slot index and cycle/theta start pulses.
//               New configurations are shadowed and take effect only at a
//               theta boundary or on a phase resync.
// Revision    : 1.0 - initial release
// ============================================================================
module nested_phase_oscillator #(
  parameter int PHASE_W    = 8,
  parameter int SLOT_W     = 3,
  parameter int DEF_LEN    = 256,
  parameter int DEF_GAMMAS = 4
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  en,
  input  wire logic                  phase_reset,
  nested_phase_oscillator_if.slave   cfg,
  output logic [PHASE_W-1:0]         phase_out,
  output logic [SLOT_W-1:0]          gamma_idx,
  output logic                       cycle_start,
  output logic                       theta_start,
  output logic [PHASE_W:0]           active_len
);

  localparam logic [0:0]        c_st_idle    = 1'b0;
  localparam logic [0:0]        c_st_pending = 1'b1;
  localparam logic [PHASE_W:0]  c_min_len    = (PHASE_W+1)'(2);
  localparam logic [PHASE_W:0]  c_max_len    = {1'b1, {PHASE_W{1'b0}}};
  localparam logic [PHASE_W:0]  c_one_len    = (PHASE_W+1)'(1);
  localparam logic [SLOT_W:0]   c_min_gam    = (SLOT_W+1)'(1);
  localparam logic [SLOT_W:0]   c_max_gam    = {1'b1, {SLOT_W{1'b0}}};

  logic [0:0]          r_state;
  logic [0:0]          w_state_nxt;
  logic [PHASE_W-1:0]  r_phase;
  logic [SLOT_W-1:0]   r_slot;
  logic                r_cycle_start;
  logic                r_theta_start;
  logic [PHASE_W:0]    r_len;
  logic [SLOT_W:0]     r_gammas;
  logic [PHASE_W:0]    r_sh_len;
  logic [SLOT_W:0]     r_sh_gammas;
  logic [PHASE_W:0]    w_clamp_len;
  logic [SLOT_W:0]     w_clamp_gam;
  logic                w_phase_last;
  logic                w_slot_last;
  logic                w_theta_bound;
  logic                w_accept;
  logic                w_apply;
  logic                w_ready;

  // Wrap detection is done at PHASE_W+1 bits so a full 2^PHASE_W length works.
  assign w_phase_last  = ({1'b0, r_phase} == (r_len - c_one_len));
  assign w_slot_last   = ({1'b0, r_slot} == (r_gammas - c_min_gam));
  assign w_theta_bound = en && w_phase_last && w_slot_last;
  assign w_accept      = cfg.cfg_valid && w_ready;
  // Only a config already pending before this cycle can be applied now.
  assign w_apply       = (r_state == c_st_pending) && (phase_reset || w_theta_bound);

  // Clamp requested values into their legal ranges at acceptance.
  always_comb begin
    w_clamp_len = cfg.cfg_cycle_len;
    if (cfg.cfg_cycle_len < c_min_len)      w_clamp_len = c_min_len;
    else if (cfg.cfg_cycle_len > c_max_len) w_clamp_len = c_max_len;
    w_clamp_gam = cfg.cfg_gammas;
    if (cfg.cfg_gammas < c_min_gam)         w_clamp_gam = c_min_gam;
    else if (cfg.cfg_gammas > c_max_gam)    w_clamp_gam = c_max_gam;
  end

  // Config FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_st_idle;
    else        r_state <= w_state_nxt;
  end

  // Config FSM next-state: accept in IDLE, release on apply.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:    if (w_accept) w_state_nxt = c_st_pending;
      c_st_pending: if (w_apply)  w_state_nxt = c_st_idle;
      default:      w_state_nxt = c_st_idle;
    endcase
  end

  // Config FSM outputs.
  always_comb begin
    w_ready = (r_state == c_st_idle);
  end

  // Shadow and active configuration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_len    <= (PHASE_W+1)'(DEF_LEN);
      r_sh_gammas <= (SLOT_W+1)'(DEF_GAMMAS);
      r_len       <= (PHASE_W+1)'(DEF_LEN);
      r_gammas    <= (SLOT_W+1)'(DEF_GAMMAS);
    end else begin
      if (w_accept) begin
        r_sh_len    <= w_clamp_len;
        r_sh_gammas <= w_clamp_gam;
      end
      if (w_apply) begin
        r_len    <= r_sh_len;
        r_gammas <= r_sh_gammas;
      end
    end
  end

  // Phase ramp, gamma slot and start pulses; resync beats enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase       <= '0;
      r_slot        <= '0;
      r_cycle_start <= 1'b0;
      r_theta_start <= 1'b0;
    end else if (phase_reset) begin
      r_phase       <= '0;
      r_slot        <= '0;
      r_cycle_start <= 1'b1;
      r_theta_start <= 1'b1;
    end else if (en) begin
      if (w_phase_last) begin
        r_phase       <= '0;
        r_cycle_start <= 1'b1;
        r_slot        <= w_slot_last ? '0 : r_slot + 1'b1;
        r_theta_start <= w_slot_last;
      end else begin
        r_phase       <= r_phase + 1'b1;
        r_cycle_start <= 1'b0;
        r_theta_start <= 1'b0;
      end
    end else begin
      r_cycle_start <= 1'b0;
      r_theta_start <= 1'b0;
    end
  end

  assign phase_out     = r_phase;
  assign gamma_idx     = r_slot;
  assign cycle_start   = r_cycle_start;
  assign theta_start   = r_theta_start;
  assign active_len    = r_len;
  assign cfg.cfg_ready = w_ready;

endmodule
`default_nettype wire

// File: tb/tb_nested_phase_oscillator.sv
`default_nettype none
// ============================================================================
// Module      : tb_nested_phase_oscillator
// Description : Directed self-checking bench for nested_phase_oscillator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nested_phase_oscillator;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       phase_reset;
  logic [7:0] phase_out;
  logic [2:0] gamma_idx;
  logic       cycle_start;
  logic       theta_start;
  logic [8:0] active_len;

  int n_pass;
  int n_total;

  nested_phase_oscillator_if #(.PHASE_W(8), .SLOT_W(3)) cfg_if ();

  nested_phase_oscillator #(
    .PHASE_W(8), .SLOT_W(3), .DEF_LEN(256), .DEF_GAMMAS(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .phase_reset (phase_reset),
    .cfg         (cfg_if),
    .phase_out   (phase_out),
    .gamma_idx   (gamma_idx),
    .cycle_start (cycle_start),
    .theta_start (theta_start),
    .active_len  (active_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int ph, input int sl,
                           input int cs, input int ts);
    check({tag, ".phase"}, int'(phase_out), ph);
    check({tag, ".slot"},  int'(gamma_idx), sl);
    check({tag, ".cs"},    int'(cycle_start), cs);
    check({tag, ".ts"},    int'(theta_start), ts);
  endtask

  task automatic offer_cfg(input int len, input int gam);
    cfg_if.cfg_valid     = 1'b1;
    cfg_if.cfg_cycle_len = 9'(len);
    cfg_if.cfg_gammas    = 4'(gam);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    en = 1'b0;
    phase_reset = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_cycle_len = '0;
    cfg_if.cfg_gammas = '0;
    repeat (3) tick();
    check_all("rst", 0, 0, 0, 0);
    check("rst.ready", int'(cfg_if.cfg_ready), 1);
    check("rst.len", int'(active_len), 256);
    rst_n = 1'b1;
    en = 1'b1;

    // Default 256 x 4 ramp over one full theta.
    for (int k = 1; k <= 1024; k++) begin
      tick();
      check_all("def", k % 256, (k / 256) % 4, int'(k % 256 == 0), int'(k % 1024 == 0));
    end

    // Accept len=5 gammas=3 mid-theta; held pending until the theta boundary.
    repeat (10) tick();
    offer_cfg(5, 3);
    check("acc.ready_before", int'(cfg_if.cfg_ready), 1);
    tick();
    cfg_if.cfg_valid = 1'b0;
    check("acc.ready_after", int'(cfg_if.cfg_ready), 0);
    repeat (1012) tick();
    check("pend.phase", int'(phase_out), 255);
    check("pend.slot", int'(gamma_idx), 3);
    check("pend.ready", int'(cfg_if.cfg_ready), 0);
    check("pend.len", int'(active_len), 256);
    tick();
    check_all("apply", 0, 0, 1, 1);
    check("apply.len", int'(active_len), 5);
    check("apply.ready", int'(cfg_if.cfg_ready), 1);
    for (int j = 1; j <= 33; j++) begin
      tick();
      check_all("len5", j % 5, (j / 5) % 3, int'(j % 5 == 0), int'(j % 15 == 0));
    end

    // Freeze at phase 3 for 7 clocks.
    en = 1'b0;
    for (int j = 0; j < 7; j++) begin
      tick();
      check_all("frz", 3, 0, 0, 0);
    end
    en = 1'b1;
    tick();
    check("resume.phase", int'(phase_out), 4);

    // Pending len=3 applied by resync at phase 2, slot 1 with en=0.
    offer_cfg(3, 2);
    tick();
    cfg_if.cfg_valid = 1'b0;
    tick();
    tick();
    check("pre_rs.phase", int'(phase_out), 2);
    check("pre_rs.slot", int'(gamma_idx), 1);
    check("pre_rs.ready", int'(cfg_if.cfg_ready), 0);
    en = 1'b0;
    phase_reset = 1'b1;
    tick();
    phase_reset = 1'b0;
    check_all("rs", 0, 0, 1, 1);
    check("rs.len", int'(active_len), 3);
    check("rs.ready", int'(cfg_if.cfg_ready), 1);
    tick();
    check_all("rs_hold", 0, 0, 0, 0);
    en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check_all("len3", k % 3, (k / 3) % 2, int'(k % 3 == 0), int'(k % 6 == 0));
    end

    // Clamp 0/0 -> 2/1.
    offer_cfg(0, 0);
    tick();
    cfg_if.cfg_valid = 1'b0;
    check("clamp0.len_before", int'(active_len), 3);
    phase_reset = 1'b1;
    tick();
    phase_reset = 1'b0;
    check("clamp0.len", int'(active_len), 2);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_all("len2", k % 2, 0, int'(k % 2 == 0), int'(k % 2 == 0));
    end

    // Clamp 300/9 -> 256/8.
    offer_cfg(300, 9);
    tick();
    cfg_if.cfg_valid = 1'b0;
    phase_reset = 1'b1;
    tick();
    phase_reset = 1'b0;
    check("clamp300.len", int'(active_len), 256);
    check_all("clamp300", 0, 0, 1, 1);
    for (int k = 1; k <= 20; k++) begin
      tick();
      check("full.phase", int'(phase_out), k);
    end

    // Asynchronous reset while a cfg (7, 2) is pending at phase 100.
    offer_cfg(7, 2);
    tick();
    cfg_if.cfg_valid = 1'b0;
    repeat (79) tick();
    check("arst_pre.phase", int'(phase_out), 100);
    check("arst_pre.ready", int'(cfg_if.cfg_ready), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("arst", 0, 0, 0, 0);
    check("arst.ready", int'(cfg_if.cfg_ready), 1);
    check("arst.len", int'(active_len), 256);
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 1024; k++) begin
      tick();
      check_all("post", k % 256, (k / 256) % 4, int'(k % 256 == 0), int'(k % 1024 == 0));
    end
    check("post.len", int'(active_len), 256);
    check("post.ready", int'(cfg_if.cfg_ready), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
